vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives the pixel coordinates x/y consumed by the board-drawing stage and the sync/blank/clock pins of the VGA DAC.
- The draw stage adds latency: one RAM read cycle plus one registered RGB stage. Sync and blank outputs are therefore delayed by a programmable number of pixel ticks, so they stay aligned with the RGB data.

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y raster counters, and sync/blank
// outputs delayed in pixel ticks to stay aligned with the pipelined RGB path.
module vga_timing_gen #(
  parameter int HRES       = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int VRES       = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(HRES);
  localparam logic [9:0] HS_BEGIN = 10'(HRES + H_FP);
  localparam logic [9:0] HS_END   = 10'(HRES + H_FP + H_SYNC);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_VIS    = 10'(VRES);
  localparam logic [9:0] VS_BEGIN = 10'(VRES + V_FP);
  localparam logic [9:0] VS_END   = 10'(VRES + V_FP + V_SYNC);
  localparam logic       POL      = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic             x_wrap;
  logic             y_wrap;
  logic             hs_raw;
  logic             vs_raw;
  logic             d_hs;
  logic             d_vs;
  logic             d_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);
  assign vga_clk  = (div_cnt >= DIV_HALF);

  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_tick) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign active = (x < X_VIS) && (y < Y_VIS);
  assign hs_raw = (x >= HS_BEGIN) && (x < HS_END);
  assign vs_raw = (y >= VS_BEGIN) && (y < VS_END);

  assign line_start  = pix_tick && x_wrap;
  assign frame_start = line_start && y_wrap;

  generate
    if (SYNC_DELAY == 0) begin : g_bypass
      assign d_hs  = hs_raw;
      assign d_vs  = vs_raw;
      // x/y are already 0 in reset, so only blanking needs forcing here.
      assign d_act = active & ~rst;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;
      logic [SYNC_DELAY-1:0] act_pipe;

      // NOTE: this shift register is a few flops, not a RAM, so it is reset
      // like any other state; that keeps sync/blank clean out of reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hs_pipe  <= '0;
          vs_pipe  <= '0;
          act_pipe <= '0;
        end else if (pix_tick) begin
          hs_pipe[0]  <= hs_raw;
          vs_pipe[0]  <= vs_raw;
          act_pipe[0] <= active;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
            act_pipe[i] <= act_pipe[i-1];
          end
        end
      end

      assign d_hs  = hs_pipe[SYNC_DELAY-1];
      assign d_vs  = vs_pipe[SYNC_DELAY-1];
      assign d_act = act_pipe[SYNC_DELAY-1];
    end
  endgenerate

  // Sync level equals POL inside the window, its complement outside.
  assign hsync   = (d_hs == POL);
  assign vsync   = (d_vs == POL);
  assign blank_n = d_act;
  assign sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size timing with and without the
// sync delay, mid-line reset, and full frames on a scaled-down raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d2_x, d2_y, d0_x, d0_y, sm_x, sm_y;
  logic d2_pt, d2_act, d2_hs, d2_vs, d2_bl, d2_sn, d2_vc, d2_fs, d2_ls;
  logic d0_pt, d0_act, d0_hs, d0_vs, d0_bl, d0_sn, d0_vc, d0_fs, d0_ls;
  logic sm_pt, sm_act, sm_hs, sm_vs, sm_bl, sm_sn, sm_vc, sm_fs, sm_ls;

  vga_timing_gen u_d2 (
    .clk(clk), .rst(rst), .x(d2_x), .y(d2_y), .pix_tick(d2_pt), .active(d2_act),
    .hsync(d2_hs), .vsync(d2_vs), .blank_n(d2_bl), .sync_n(d2_sn), .vga_clk(d2_vc),
    .frame_start(d2_fs), .line_start(d2_ls)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .clk(clk), .rst(rst), .x(d0_x), .y(d0_y), .pix_tick(d0_pt), .active(d0_act),
    .hsync(d0_hs), .vsync(d0_vs), .blank_n(d0_bl), .sync_n(d0_sn), .vga_clk(d0_vc),
    .frame_start(d0_fs), .line_start(d0_ls)
  );

  // 15 x 8 raster, 3 clk per pixel, one-tick delay, active-high sync.
  vga_timing_gen #(
    .HRES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .VRES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .SYNC_DELAY(1), .SYNC_POL(1)
  ) u_sm (
    .clk(clk), .rst(rst), .x(sm_x), .y(sm_y), .pix_tick(sm_pt), .active(sm_act),
    .hsync(sm_hs), .vsync(sm_vs), .blank_n(sm_bl), .sync_n(sm_sn), .vga_clk(sm_vc),
    .frame_start(sm_fs), .line_start(sm_ls)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  // Advance to the negedge following rising edge k after reset release.
  task automatic step_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    int k;
    int x;
    int y;
    int pt;
    int vc;
    int ls;
    int fs;
    int hs2;
    int bl2;
    int hs0;
    int bl0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int hs2_lo, hs0_lo, bl0_lo, ls_cnt;
    int fs_cnt, fs_first, fs_prev, max_x, max_y, sm_hs_hi, sm_vs_hi, sm_ls_cnt;

    //              k     x    y  pt vc ls fs hs2 bl2 hs0 bl0
    vecs.push_back('{1,    0,   0, 1, 1, 0, 0, 1,  0,  1,  1});
    vecs.push_back('{2,    1,   0, 0, 0, 0, 0, 1,  0,  1,  1});
    vecs.push_back('{3,    1,   0, 1, 1, 0, 0, 1,  0,  1,  1});
    vecs.push_back('{4,    2,   0, 0, 0, 0, 0, 1,  1,  1,  1});
    vecs.push_back('{1280, 640, 0, 0, 0, 0, 0, 1,  1,  1,  0});
    vecs.push_back('{1283, 641, 0, 1, 1, 0, 0, 1,  1,  1,  0});
    vecs.push_back('{1284, 642, 0, 0, 0, 0, 0, 1,  0,  1,  0});
    vecs.push_back('{1311, 655, 0, 1, 1, 0, 0, 1,  0,  1,  0});
    vecs.push_back('{1312, 656, 0, 0, 0, 0, 0, 1,  0,  0,  0});
    vecs.push_back('{1315, 657, 0, 1, 1, 0, 0, 1,  0,  0,  0});
    vecs.push_back('{1316, 658, 0, 0, 0, 0, 0, 0,  0,  0,  0});
    vecs.push_back('{1503, 751, 0, 1, 1, 0, 0, 0,  0,  0,  0});
    vecs.push_back('{1504, 752, 0, 0, 0, 0, 0, 0,  0,  1,  0});
    vecs.push_back('{1507, 753, 0, 1, 1, 0, 0, 0,  0,  1,  0});
    vecs.push_back('{1508, 754, 0, 0, 0, 0, 0, 1,  0,  1,  0});
    vecs.push_back('{1598, 799, 0, 0, 0, 0, 0, 1,  0,  1,  0});
    vecs.push_back('{1599, 799, 0, 1, 1, 1, 0, 1,  0,  1,  0});
    vecs.push_back('{1600, 0,   1, 0, 0, 0, 0, 1,  0,  1,  1});
    vecs.push_back('{1604, 2,   1, 0, 0, 0, 0, 1,  1,  1,  1});

    // Values held while reset is asserted.
    repeat (2) @(negedge clk);
    check("rst_x", d2_x, 0);
    check("rst_y", d2_y, 0);
    check("rst_pix_tick", d2_pt, 0);
    check("rst_active", d2_act, 1);
    check("rst_hsync", d2_hs, 1);
    check("rst_vsync", d2_vs, 1);
    check("rst_blank_n", d2_bl, 0);
    check("rst_blank_n_d0", d0_bl, 0);
    check("rst_sync_n", d2_sn, 0);
    check("rst_vga_clk", d2_vc, 0);
    check("rst_line_start", d2_ls, 0);
    check("rst_frame_start", d2_fs, 0);
    check("rst_hsync_pol1", sm_hs, 0);
    check("rst_vsync_pol1", sm_vs, 0);
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      step_to(vecs[i].k);
      check($sformatf("v%0d_x", vecs[i].k), d2_x, vecs[i].x);
      check($sformatf("v%0d_y", vecs[i].k), d2_y, vecs[i].y);
      check($sformatf("v%0d_pix_tick", vecs[i].k), d2_pt, vecs[i].pt);
      check($sformatf("v%0d_vga_clk", vecs[i].k), d2_vc, vecs[i].vc);
      check($sformatf("v%0d_line_start", vecs[i].k), d2_ls, vecs[i].ls);
      check($sformatf("v%0d_frame_start", vecs[i].k), d2_fs, vecs[i].fs);
      check($sformatf("v%0d_hsync_d2", vecs[i].k), d2_hs, vecs[i].hs2);
      check($sformatf("v%0d_blank_n_d2", vecs[i].k), d2_bl, vecs[i].bl2);
      check($sformatf("v%0d_hsync_d0", vecs[i].k), d0_hs, vecs[i].hs0);
      check($sformatf("v%0d_blank_n_d0", vecs[i].k), d0_bl, vecs[i].bl0);
    end

    // One full line period of clk: per-line totals are window-independent.
    hs2_lo = 0; hs0_lo = 0; bl0_lo = 0; ls_cnt = 0;
    repeat (1600) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      hs2_lo += (d2_hs == 1'b0) ? 1 : 0;
      hs0_lo += (d0_hs == 1'b0) ? 1 : 0;
      bl0_lo += (d0_bl == 1'b0) ? 1 : 0;
      ls_cnt += d0_ls ? 1 : 0;
    end
    check("line_hsync_low_clk_d2", hs2_lo, 192);
    check("line_hsync_low_clk_d0", hs0_lo, 192);
    check("line_blank_low_clk_d0", bl0_lo, 320);
    check("line_start_per_line", ls_cnt, 1);

    // Reset in the middle of the horizontal sync pulse.
    do_reset();
    step_to(1400);
    check("mid_x_before", d2_x, 700);
    check("mid_hsync_d2_before", d2_hs, 0);
    check("mid_hsync_d0_before", d0_hs, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_x", d2_x, 0);
    check("mid_rst_y", d2_y, 0);
    check("mid_rst_vga_clk", d2_vc, 0);
    check("mid_rst_hsync_d2", d2_hs, 1);
    check("mid_rst_hsync_d0", d0_hs, 1);
    check("mid_rst_blank_n", d2_bl, 0);
    hs2_lo = 0; hs0_lo = 0;
    repeat (3) begin
      @(negedge clk);
      hs2_lo += (d2_hs == 1'b0) ? 1 : 0;
      hs0_lo += (d0_hs == 1'b0) ? 1 : 0;
    end
    rst = 1'b0;
    cyc = 0;
    repeat (40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      hs2_lo += (d2_hs == 1'b0) ? 1 : 0;
      hs0_lo += (d0_hs == 1'b0) ? 1 : 0;
      if (cyc == 2) check("mid_resume_x", d2_x, 1);
    end
    check("mid_no_runt_d2", hs2_lo, 0);
    check("mid_no_runt_d0", hs0_lo, 0);
    check("mid_resume_x_late", d2_x, 20);
    check("mid_resume_y_late", d2_y, 0);

    // Three full frames on the scaled raster (360 clk per frame).
    do_reset();
    fs_cnt = 0; fs_first = -1; fs_prev = -1; max_x = 0; max_y = 0;
    sm_hs_hi = 0; sm_vs_hi = 0; sm_ls_cnt = 0;
    repeat (1100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (int'(sm_x) > max_x) max_x = int'(sm_x);
      if (int'(sm_y) > max_y) max_y = int'(sm_y);
      if (cyc <= 1080) begin
        sm_hs_hi += sm_hs ? 1 : 0;
        sm_vs_hi += sm_vs ? 1 : 0;
        sm_ls_cnt += sm_ls ? 1 : 0;
      end
      if (sm_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc;
        else check("sm_frame_period", cyc - fs_prev, 360);
        fs_prev = cyc;
      end
    end
    check("sm_first_frame_start", fs_first, 359);
    check("sm_frame_count", fs_cnt, 3);
    check("sm_max_x", max_x, 14);
    check("sm_max_y", max_y, 7);
    check("sm_hsync_high_clk", sm_hs_hi, 216);
    check("sm_vsync_high_clk", sm_vs_hi, 270);
    check("sm_line_count", sm_ls_cnt, 24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
